fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the IF stage.
- Owns the architectural PC register and issues one-outstanding-request fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to decode through a valid/ready output slot.
- Applies jump/branch redirects from EX, discarding any stale in-flight response.
- Replaces the free-running PC flop/mux once instruction memory has non-zero latency.

Parameters:
- PC_RESET_VALUE, 32'h0, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  one-cycle pulse from EX: jump or taken branch.
- redirect_pc  in  32  target PC, qualified by redirect_valid.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to current PC register.
- imem_gnt  in  1  request accepted this cycle, when imem_req is high.
- imem_rvalid  in  1  response data valid; at most one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  output slot holds an instruction.
- if_instr  out  32  instruction in the output slot.
- if_pc  out  32  PC of if_instr.
- if_pc_plus_4  out  32  if_pc + 4.
- if_ready  in  1  decode consumes the slot when if_valid and if_ready are both high.
- if_fault  out  1  misaligned redirect target; fetch halted.

Behaviour:
- Reset (rst high at edge):
  - state=REQ, pc=PC_RESET_VALUE, kill=0, if_valid=0, if_instr=0, if_pc=0, if_fault=0.
  - imem_req is forced 0 while rst is high.
- imem_req and imem_addr are combinational from state. First request goes out in the first cycle with rst low, addr=PC_RESET_VALUE.
- State REQ:
  - imem_req = !if_valid || if_ready. The slot must be free or draining, which guarantees response space and removes the need for a skid buffer.
  - On imem_req && imem_gnt: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0), then go to WAIT.
  - Once asserted, imem_req and imem_addr are held until gnt. The only exception is a redirect, which may change the address; imem must tolerate this.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=0: if_instr <= imem_rdata, if_pc <= pc-4, if_valid <= 1, go to REQ.
  - On imem_rvalid with kill=1: discard the data, clear kill, go to REQ.
- State FAULT:
  - imem_req=0, if_fault=1. Leave only on a redirect or reset.
- Output slot:
  - if_valid clears on consume unless it is refilled in the same cycle.
  - Back-to-back throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect (redirect_valid high). Highest priority over all other events in the same cycle:
  - pc <= redirect_pc and if_valid <= 0 (squash the slot, even if if_ready is high).
  - kill <= 1 if a request is outstanding: state WAIT without rvalid this cycle, or REQ with gnt this cycle. Otherwise kill <= 0.
  - Redirect together with gnt: the granted old-PC request is killed and the next request uses redirect_pc.
  - Redirect together with a valid (non-killed) rvalid: the response is discarded.
  - If redirect_pc[1:0] != 0: go to FAULT, if_fault=1, and hold any outstanding response in kill. The FAULT exit is deferred until kill clears.
  - Otherwise: next state = WAIT if kill is being set, else REQ.
- Reset mid-WAIT: outstanding state is dropped. Memory responses arriving after reset while in REQ are ignored, since rvalid is sampled only in WAIT.
- if_pc_plus_4 = if_pc + 4, combinational, wrapping.

Decomposition:
- Shared package (cpu_pkg): state encoding enum {REQ, WAIT, FAULT}, XLEN=32, INSTR_ALIGN_MASK=2'b11.
- One natural sub-module: reuse pc_prefix_adder for both pc+4 and if_pc+4. No other sub-modules.

Test Plan:
- Reset release, imem gnt immediate, rvalid 1 cycle later, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 each valid 1 cycle; one instruction per 2 cycles.
- if_ready=0 with slot holding pc 0x4 -> imem_req stays 0, if_instr stable. Raise if_ready -> imem_req rises the same cycle with addr 0x8.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data never reaches if_valid; next request addr 0x100; first if_pc=0x100.
- Redirect to 0x200 coincident with gnt of addr 0x8 -> 0x8 response dropped, next imem_addr 0x200.
- Redirect to 0x102 -> if_fault=1, imem_req=0 indefinitely. Redirect to 0x300 -> if_fault=0, fetch resumes at 0x300.
- PC_RESET_VALUE=32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0; if_pc_plus_4=0 for the first instruction.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the IF-stage fetch controller
package fetch_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;
    typedef enum logic [1:0] {REQ, WAIT, FAULT} fetch_state_t;
    function automatic logic misaligned(input logic [XLEN-1:0] pc);
        return |(pc[1:0] & INSTR_ALIGN_MASK);
    endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect input, instruction-memory handshake and decode output slot
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus_4;
    logic            if_ready;
    logic            if_fault;
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4, if_fault
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4, if_fault
    );
endinterface

// File: rtl/fetch_ctrl_pc_prefix_adder.sv
// pc_prefix_adder: sequential-instruction PC increment (wrapping +4)
module pc_prefix_adder
    import fetch_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] a,
    output logic [XLEN-1:0] y
);
    assign y = a + XLEN'(4);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner issuing one-outstanding imem fetches into a single decode slot,
// with redirect handling that discards stale in-flight responses.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET_VALUE = '0
) (
    input logic clk,
    input logic rst,
    fetch_ctrl_if.master bus
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc, pc_next4, slot_instr, slot_pc;
    logic            kill, slot_valid, fault;
    logic            req, grant, outstanding, consume, bad_target;
    pc_prefix_adder u_pc_inc (.a(pc), .y(pc_next4));
    pc_prefix_adder u_if_inc (.a(slot_pc), .y(bus.if_pc_plus_4));
    // requesting only when the slot is free or draining means a response always has room
    assign req         = !rst && state == REQ && (!slot_valid || bus.if_ready);
    assign grant       = req && bus.imem_gnt;
    assign consume     = slot_valid && bus.if_ready;
    assign bad_target  = misaligned(bus.redirect_pc);
    assign outstanding = grant || ((state == WAIT || (state == FAULT && kill)) && !bus.imem_rvalid);
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = slot_valid;
    assign bus.if_instr  = slot_instr;
    assign bus.if_pc     = slot_pc;
    assign bus.if_fault  = fault;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= PC_RESET_VALUE;
            kill       <= 1'b0;
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
            fault      <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc         <= bus.redirect_pc;
            slot_valid <= 1'b0;
            kill       <= outstanding;
            fault      <= bad_target;
            state      <= bad_target ? FAULT : outstanding ? WAIT : REQ;
        end else begin
            if (consume)
                slot_valid <= 1'b0;
            case (state)
                REQ: if (grant) begin
                    pc    <= pc_next4;
                    state <= WAIT;
                end
                WAIT: if (bus.imem_rvalid) begin
                    if (!kill) begin
                        slot_instr <= bus.imem_rdata;
                        slot_pc    <= pc - XLEN'(4);
                        slot_valid <= 1'b1;
                    end
                    kill  <= 1'b0;
                    state <= REQ;
                end
                // a response still owed when the fault was taken just retires the kill
                default: if (bus.imem_rvalid) kill <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench; expected stream is the program-order PC sequence
// restarted at every redirect/reset, with instruction words derived from a fixed memory function.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;
    localparam logic [31:0] RST_PC = 32'h0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0, fails = 0, consumed = 0;
    always #5 clk = ~clk;
    fetch_ctrl_if bus();
    fetch_ctrl_if wbus();
    fetch_ctrl #(.PC_RESET_VALUE(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_ctrl #(.PC_RESET_VALUE(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst(rst), .bus(wbus));
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    // second instance: always-ready decode and a fixed 1-cycle memory
    logic        w_rv = 1'b0;
    logic [31:0] w_addr = '0;
    assign wbus.imem_gnt       = wbus.imem_req;
    assign wbus.imem_rvalid    = w_rv;
    assign wbus.imem_rdata     = mem_word(w_addr);
    assign wbus.if_ready       = 1'b1;
    assign wbus.redirect_valid = 1'b0;
    assign wbus.redirect_pc    = '0;
    always @(posedge clk) begin
        w_rv   <= !rst && wbus.imem_req;
        w_addr <= wbus.imem_addr;
    end
    initial begin
        int seen = 0, prev_c = 0;
        logic [31:0] e;
        do @(negedge clk); while (rst);
        for (int c = 0; c < 12 && seen < 3; c++) begin
            if (c == 0) begin
                check("wrap_first_req", wbus.imem_req, 1);
                check("wrap_first_addr", wbus.imem_addr, 32'hFFFF_FFFC);
            end
            if (wbus.if_valid) begin
                e = 32'hFFFF_FFFC + 32'(4 * seen);
                check("wrap_if_pc", wbus.if_pc, e);
                check("wrap_instr", wbus.if_instr, mem_word(e));
                check("wrap_pc_plus_4", wbus.if_pc_plus_4, e + 32'd4);
                if (seen > 0) check("wrap_spacing", 32'(c - prev_c), 2);
                prev_c = c;
                seen++;
            end
            @(negedge clk);
        end
        check("wrap_count", 32'(seen), 3);
    end
    // memory model and stimulus
    logic        pend = 1'b0;
    int          lat = 0;
    logic [31:0] paddr = '0;
    task automatic step(input bit r, input int ready_pct, input int redir_pct,
                        input bit force_redir, input logic [31:0] force_pc);
        logic [1:0] lo;
        rst = r;
        bus.imem_rvalid = 1'b0;
        if (r) pend = 1'b0;
        else if (pend) begin
            if (lat == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(paddr);
                pend = 1'b0;
            end else lat--;
        end
        bus.if_ready = $urandom_range(99) < ready_pct;
        lo = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        bus.redirect_valid = !r && (force_redir || $urandom_range(99) < redir_pct);
        bus.redirect_pc    = force_redir ? force_pc : {20'h0, 10'($urandom), lo};
        #1;
        bus.imem_gnt = !pend && bus.imem_req && $urandom_range(1) == 1;
        if (bus.imem_gnt) begin
            pend  = 1'b1;
            paddr = bus.imem_addr;
            lat   = $urandom_range(2);
        end
        @(posedge clk);
        #1;
    endtask
    // monitor / scoreboard
    logic [31:0] expq[$];
    logic [31:0] hold_pc, hold_instr, hold_addr, e;
    bit prev_rst = 1'b0, exp_fault = 1'b0, hold_chk = 1'b0, req_hold_chk = 1'b0;
    int idle = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_rst) begin
                check("rst_if_valid", bus.if_valid, 0);
                check("rst_if_fault", bus.if_fault, 0);
                check("rst_if_pc", bus.if_pc, 0);
                check("rst_if_instr", bus.if_instr, 0);
            end
            check("rst_req_low", bus.imem_req, 0);
            expq.delete();
            expq.push_back(RST_PC);
            exp_fault = 1'b0;
            idle = 0;
            hold_chk = 1'b0;
            req_hold_chk = 1'b0;
        end else begin
            if (prev_rst) begin
                check("first_req", bus.imem_req, 1);
                check("first_addr", bus.imem_addr, RST_PC);
            end
            check("fault_flag", bus.if_fault, exp_fault);
            if (exp_fault) check("fault_req_low", bus.imem_req, 0);
            if (hold_chk) begin
                check("slot_hold_valid", bus.if_valid, 1);
                check("slot_hold_pc", bus.if_pc, hold_pc);
                check("slot_hold_instr", bus.if_instr, hold_instr);
            end
            if (req_hold_chk) begin
                check("req_hold", bus.imem_req, 1);
                check("req_hold_addr", bus.imem_addr, hold_addr);
            end
            if (bus.if_valid && !bus.if_ready) check("req_blocked", bus.imem_req, 0);
            hold_chk     = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
            hold_pc      = bus.if_pc;
            hold_instr   = bus.if_instr;
            req_hold_chk = bus.imem_req && !bus.imem_gnt && !bus.redirect_valid;
            hold_addr    = bus.imem_addr;
            if (bus.redirect_valid) begin
                expq.delete();
                exp_fault = |bus.redirect_pc[1:0];
                if (!exp_fault) expq.push_back(bus.redirect_pc);
                idle = 0;
            end else if (bus.if_valid && bus.if_ready) begin
                consumed++;
                idle = 0;
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_instr: got pc %h, expected no instruction", bus.if_pc);
                end else begin
                    e = expq.pop_front();
                    check("if_pc", bus.if_pc, e);
                    check("if_instr", bus.if_instr, mem_word(e));
                    check("if_pc_plus_4", bus.if_pc_plus_4, e + 32'd4);
                    expq.push_back(e + 32'd4);
                end
            end else if (!exp_fault) begin
                idle++;
                if (idle > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL stall: got no instruction for %0d cycles, expected progress", idle);
                    idle = 0;
                end
            end
        end
        prev_rst = rst;
    end
    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.if_ready       = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1, 0, 0, 0, '0);
        repeat (20) step(0, 100, 0, 0, '0);
        repeat (10) step(0, 0, 0, 0, '0);
        repeat (10) step(0, 100, 0, 0, '0);
        step(0, 100, 0, 1, 32'h0000_0102);
        repeat (20) step(0, 100, 0, 0, '0);
        step(0, 100, 0, 1, 32'h0000_0300);
        repeat (20) step(0, 100, 0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1000 || i == 2000) repeat (2) step(1, 50, 0, 0, '0);
            else step(0, 70, 4, 0, '0);
        end
        repeat (30) step(0, 100, 0, 0, '0);
        check("consumed_enough", 32'(consumed > 300), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
